// File: rtl/mcdf_arbiter_rr.sv
// MCDF channel arbiter: picks the best-priority eligible channel on a formatter ID
// request, breaks ties round-robin (or lowest index), and holds the grant until done.
module mcdf_arbiter_rr #(
    parameter int NUM_CH = 4,
    parameter int PRIO_W = 2,
    parameter bit RR_EN  = 1'b1,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        slv_req_i,
    input  logic [NUM_CH-1:0]        slv_en_i,
    input  logic [NUM_CH*PRIO_W-1:0] slv_prio_i,
    input  logic                     f2a_id_req_i,
    input  logic                     f2a_done_i,
    output logic                     a2f_val_o,
    output logic [CH_W-1:0]          a2f_id_o,
    output logic [NUM_CH-1:0]        a2s_ack_o,
    output logic                     busy_o,
    output logic [1:0]               dbg_state_o
);

    // Handshake: f2a_id_req_i is a level request; the arbiter answers with a one-cycle
    // a2f_val_o/a2s_ack_o pulse, then stays busy until the one-cycle f2a_done_i pulse.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_last_ptr;
    logic                r_val;
    logic [CH_W-1:0]     r_id;
    logic [NUM_CH-1:0]   r_ack;
    logic                r_busy;
    logic                w_val_nxt;
    logic [CH_W-1:0]     w_id_nxt;
    logic [NUM_CH-1:0]   w_ack_nxt;
    logic                w_busy_nxt;
    logic [NUM_CH-1:0]   w_elig;
    logic [PRIO_W-1:0]   w_prio [NUM_CH];
    logic [PRIO_W-1:0]   w_min_prio;
    logic [CH_W-1:0]     w_sel;
    logic                w_found;
    logic                w_go;

    assign w_elig = slv_req_i & slv_en_i;
    assign w_go   = f2a_id_req_i && (|w_elig);

    always_comb begin
        w_min_prio = '1;
        for (int k = 0; k < NUM_CH; k++) begin
            w_prio[k] = slv_prio_i[k*PRIO_W +: PRIO_W];
            if (w_elig[k] && (w_prio[k] < w_min_prio)) begin
                w_min_prio = w_prio[k];
            end
        end
    end

    // Scan order starts just after the last grant (RR) or at channel 0 (legacy).
    always_comb begin
        int              c;
        logic [CH_W-1:0] c_idx;
        w_sel   = '0;
        w_found = 1'b0;
        c       = 0;
        c_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = RR_EN ? (int'(r_last_ptr) + i) : (i - 1);
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end
            c_idx = CH_W'(c);
            if (!w_found && w_elig[c_idx] && (w_prio[c_idx] == w_min_prio)) begin
                w_found = 1'b1;
                w_sel   = c_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_last_ptr <= CH_W'(NUM_CH - 1);
            r_val      <= 1'b0;
            r_id       <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_val   <= w_val_nxt;
            r_id    <= w_id_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            if ((r_state == ST_IDLE) && w_go) begin
                r_last_ptr <= w_sel;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_go) w_state_nxt = ST_GRANT;
            ST_GRANT: w_state_nxt = ST_BUSY;
            ST_BUSY:  if (f2a_done_i) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_val_nxt  = 1'b0;
        w_id_nxt   = r_id;
        w_ack_nxt  = '0;
        w_busy_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_val_nxt  = 1'b1;
                    w_id_nxt   = w_sel;
                    w_ack_nxt  = NUM_CH'(1) << w_sel;
                    w_busy_nxt = 1'b1;
                end
            end
            ST_GRANT: w_busy_nxt = 1'b1;
            ST_BUSY:  w_busy_nxt = !f2a_done_i;
            default:  w_busy_nxt = 1'b0;
        endcase
    end

    assign a2f_val_o   = r_val;
    assign a2f_id_o    = r_id;
    assign a2s_ack_o   = r_ack;
    assign busy_o      = r_busy;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mcdf_arbiter_rr.sv
// Bench for mcdf_arbiter_rr: a round-robin instance and a legacy instance share stimulus;
// expected grants come from a priority/rotation reference model.
module tb_mcdf_arbiter_rr;

    localparam int NUM_CH = 4;
    localparam int PRIO_W = 2;
    localparam int CH_W   = 2;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic [NUM_CH-1:0]        slv_req_i;
    logic [NUM_CH-1:0]        slv_en_i;
    logic [NUM_CH*PRIO_W-1:0] slv_prio_i;
    logic                     f2a_id_req_i;
    logic                     f2a_done_i;

    logic                     a2f_val_o, lg_val_o;
    logic [CH_W-1:0]          a2f_id_o, lg_id_o;
    logic [NUM_CH-1:0]        a2s_ack_o, lg_ack_o;
    logic                     busy_o, lg_busy_o;
    logic [1:0]               dbg_state_o, lg_state_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_ptr = NUM_CH - 1;
    int prev_val_cyc = 0;

    mcdf_arbiter_rr #(.NUM_CH(NUM_CH), .PRIO_W(PRIO_W), .RR_EN(1'b1)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .slv_req_i(slv_req_i), .slv_en_i(slv_en_i),
        .slv_prio_i(slv_prio_i), .f2a_id_req_i(f2a_id_req_i), .f2a_done_i(f2a_done_i),
        .a2f_val_o(a2f_val_o), .a2f_id_o(a2f_id_o), .a2s_ack_o(a2s_ack_o),
        .busy_o(busy_o), .dbg_state_o(dbg_state_o)
    );

    mcdf_arbiter_rr #(.NUM_CH(NUM_CH), .PRIO_W(PRIO_W), .RR_EN(1'b0)) u_dut_lg (
        .clk_i(clk_i), .rst_i(rst_i), .slv_req_i(slv_req_i), .slv_en_i(slv_en_i),
        .slv_prio_i(slv_prio_i), .f2a_id_req_i(f2a_id_req_i), .f2a_done_i(f2a_done_i),
        .a2f_val_o(lg_val_o), .a2f_id_o(lg_id_o), .a2s_ack_o(lg_ack_o),
        .busy_o(lg_busy_o), .dbg_state_o(lg_state_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: lowest priority value wins; among ties, first in scan order.
    function automatic int pick(input logic [NUM_CH-1:0] e, input logic [NUM_CH*PRIO_W-1:0] pr,
                                input int last, input bit rr);
        int minp;
        int c;
        minp = 1 << PRIO_W;
        for (int k = 0; k < NUM_CH; k++)
            if (e[k] && int'(pr[k*PRIO_W +: PRIO_W]) < minp) minp = int'(pr[k*PRIO_W +: PRIO_W]);
        for (int i = 1; i <= NUM_CH; i++) begin
            c = rr ? (last + i) % NUM_CH : i - 1;
            if (e[c] && int'(pr[c*PRIO_W +: PRIO_W]) == minp) return c;
        end
        return -1;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, ".val"}, a2f_val_o, 0);
        chk({tag, ".ack"}, a2s_ack_o, 0);
        chk({tag, ".busy"}, busy_o, 0);
        chk({tag, ".state"}, dbg_state_o, 0);
        chk({tag, ".lg_val"}, lg_val_o, 0);
    endtask

    // One full transaction: arbitrate, GRANT, BUSY with done (id_req kept high), back to IDLE.
    task automatic run_txn(input logic [NUM_CH-1:0] req, input logic [NUM_CH-1:0] en,
                           input logic [NUM_CH*PRIO_W-1:0] pr, input bit chk_gap, input string tag);
        int exp_rr;
        int exp_lg;
        int waited;
        exp_rr = pick(req & en, pr, last_ptr, 1'b1);
        exp_lg = pick(req & en, pr, 0, 1'b0);
        slv_req_i    = req;
        slv_en_i     = en;
        slv_prio_i   = pr;
        f2a_id_req_i = 1'b1;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!a2f_val_o && waited < 8);
        chk({tag, ".latency"}, waited, 1);
        if (chk_gap) chk({tag, ".gap"}, cyc - prev_val_cyc, 3);
        prev_val_cyc = cyc;
        chk({tag, ".id"}, a2f_id_o, exp_rr);
        chk({tag, ".ack"}, a2s_ack_o, 32'd1 << exp_rr);
        chk({tag, ".busy"}, busy_o, 1);
        chk({tag, ".state_grant"}, dbg_state_o, 1);
        chk({tag, ".lg_val"}, lg_val_o, 1);
        chk({tag, ".lg_id"}, lg_id_o, exp_lg);
        chk({tag, ".lg_ack"}, lg_ack_o, 32'd1 << exp_lg);
        last_ptr = exp_rr;
        slv_req_i = NUM_CH'($urandom);
        step();
        chk({tag, ".busy_val"}, a2f_val_o, 0);
        chk({tag, ".busy_ack"}, a2s_ack_o, 0);
        chk({tag, ".busy_hold"}, busy_o, 1);
        chk({tag, ".state_busy"}, dbg_state_o, 2);
        chk({tag, ".id_hold"}, a2f_id_o, exp_rr);
        f2a_done_i = 1'b1;
        step();
        f2a_done_i = 1'b0;
        chk({tag, ".busy_fall"}, busy_o, 0);
        chk({tag, ".state_idle"}, dbg_state_o, 0);
        chk({tag, ".lg_busy_fall"}, lg_busy_o, 0);
    endtask

    initial begin
        logic [NUM_CH-1:0]        r_req;
        logic [NUM_CH-1:0]        r_en;
        logic [NUM_CH*PRIO_W-1:0] r_pr;

        rst_i = 1'b1; slv_req_i = '0; slv_en_i = '1; slv_prio_i = '0;
        f2a_id_req_i = 1'b1; f2a_done_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
        chk("reset.id", a2f_id_o, 0);
        check_quiet("reset");
        for (int i = 0; i < 10; i++) begin
            step();
            check_quiet("idle_noreq");
        end

        for (int i = 0; i < 5; i++) run_txn(4'b1111, 4'b1111, 8'h55, i > 0, "rr_equal");
        for (int i = 0; i < 3; i++) run_txn(4'b1110, 4'b1111, 8'h55, 1'b1, "legacy_no_ch0");
        for (int i = 0; i < 4; i++) run_txn(4'b1111, 4'b1111, 8'h23, 1'b1, "prio_dom");

        run_txn(4'b1000, 4'b1111, 8'h55, 1'b1, "mask_pre");
        run_txn(4'b0011, 4'b1110, 8'h55, 1'b1, "mask_en");
        run_txn(4'b0011, 4'b1111, 8'h55, 1'b1, "mask_wrap");

        slv_req_i = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_quiet("idle_e0");
        end
        run_txn(4'b0100, 4'b1111, 8'h55, 1'b0, "e0_release");

        slv_req_i = 4'b0100; slv_en_i = 4'b1111; slv_prio_i = 8'h55;
        step();
        chk("rst_mid.grant_id", a2f_id_o, 2);
        step();
        chk("rst_mid.busy", busy_o, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rst_mid.id", a2f_id_o, 0);
        chk("rst_mid.lg_id", lg_id_o, 0);
        check_quiet("rst_mid");
        last_ptr = NUM_CH - 1;
        run_txn(4'b1111, 4'b1111, 8'h55, 1'b0, "rst_restart");

        for (int i = 0; i < 40; i++) begin
            r_req = NUM_CH'($urandom_range(1, 15));
            r_en  = NUM_CH'($urandom_range(0, 15));
            if ((r_req & r_en) == '0) r_en = r_req;
            r_pr  = (NUM_CH*PRIO_W)'($urandom);
            run_txn(r_req, r_en, r_pr, 1'b1, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mcdf_arbiter_rr.md
Name: mcdf_arbiter_rr

Overview:
- Parametrised next-generation channel arbiter for the MCDF.
- Sits between the per-channel slave FIFOs and the formatter.
- On each formatter ID request, picks one eligible channel. Ranking is by programmable priority; ties are broken round-robin (or fixed-index in legacy mode).
- Holds that grant until the formatter reports packet completion.

Parameters:
- NUM_CH, 4, number of slave channels (2..16).
- PRIO_W, 2, priority field width per channel; value 0 is highest priority.
- RR_EN, 1, 1 = round-robin tie-break among equal priorities; 0 = lowest channel index wins (legacy).
- CH_W, $clog2(NUM_CH) (minimum 1), width of the channel ID.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- slv_req_i  in  NUM_CH  per-channel request: FIFO holds a full packet.
- slv_en_i  in  NUM_CH  per-channel enable from the control registers.
- slv_prio_i  in  NUM_CH*PRIO_W  packed priorities; channel k occupies [k*PRIO_W +: PRIO_W].
- f2a_id_req_i  in  1  formatter ready for the next channel ID (level).
- f2a_done_i  in  1  formatter finished the current packet (1-cycle pulse).
- a2f_val_o  out  1  1-cycle pulse: a2f_id_o is newly valid.
- a2f_id_o  out  CH_W  granted channel ID; holds until the next grant.
- a2s_ack_o  out  NUM_CH  one-hot 1-cycle ack to the granted slave, coincident with a2f_val_o.
- busy_o  out  1  high from the grant cycle through the cycle f2a_done_i is seen.

Behaviour:
- Reset (rst_i high at an edge):
  - state=IDLE.
  - a2f_val_o=0, a2f_id_o=0, a2s_ack_o=0, busy_o=0.
  - last_ptr=NUM_CH-1, so the first round-robin search starts at ch0.
  - Reset overrides everything, including mid-BUSY; the aborted grant is not re-issued.
- Eligible set: E = slv_req_i & slv_en_i.
- Selection, combinational on current inputs:
  - Find minimum priority p among channels in E.
  - RR_EN=1: first channel with prio==p, scanning last_ptr+1, last_ptr+2, ... modulo NUM_CH.
  - RR_EN=0: lowest-index channel with prio==p.
- FSM, all outputs registered:
  - IDLE: if f2a_id_req_i && E!=0, latch sel into a2f_id_o, set a2s_ack_o[sel]=1, set last_ptr=sel, go GRANT. Otherwise stay in IDLE with no outputs asserted.
  - GRANT (1 cycle): a2f_val_o=1, a2s_ack_o one-hot, busy_o=1. Always go BUSY next.
  - BUSY: busy_o=1, a2f_val_o=0, a2s_ack_o=0. On f2a_done_i go IDLE; busy_o falls the cycle after done.
- Latency: id_req plus eligible request sampled at edge n gives a2f_val_o/ack high in cycle n+1.
  - Minimum grant-to-grant spacing is 3 cycles: GRANT, BUSY (done), IDLE arbitrate.
- Boundary conditions:
  - f2a_done_i in IDLE or GRANT is ignored. The formatter must not pulse done before BUSY.
  - f2a_id_req_i and f2a_done_i high together in BUSY: leave BUSY; arbitrate in IDLE on the next edge.
  - Request or enable dropping during GRANT/BUSY does not revoke the grant.
  - A channel disabled while in IDLE is excluded immediately.
  - Priority change takes effect at the next IDLE arbitration.
  - Pointer wrap: last_ptr=NUM_CH-1 wraps so ch0 is searched first.
  - All eligible at the same priority with RR_EN=1 gives a strict rotation.
  - id_req held high with E=0: stay IDLE indefinitely; grant in the first cycle E becomes nonzero.
- Width rules:
  - Priority compare is unsigned PRIO_W-bit.
  - a2f_id_o is zero-extended to CH_W.
  - No arithmetic overflow paths exist; pointer increment is modulo NUM_CH, including non-power-of-two NUM_CH.

Test Plan:
1. Reset then idle: hold rst_i for 2 cycles, all reqs low, id_req=1 for 10 cycles -> all outputs 0, state stays IDLE.
2. Round-robin (NUM_CH=4, RR_EN=1): all prios=1, all req/en=1, id_req=1, done pulsed 1 cycle after each grant -> IDs 0,1,2,3,0. Each a2s_ack_o one-hot matches the ID, and val pulses are exactly 3 cycles apart.
3. Priority dominance: prios {3,0,2,0}, all requesting -> IDs alternate 1,3,1,3. Channels 0 and 2 are never granted while 1 and 3 request.
4. Legacy mode (RR_EN=0): same stimulus as test 2 -> ID 0 every time. With ch0 req=0 -> ID 1 every time.
5. Enable masking and wrap: last grant=3, reqs {1,1,0,0}, slv_en_i=4'b1110 -> ID 1. Then with en=4'b1111 -> ID 0.
6. Reset mid-BUSY: grant ch2, assert rst_i in BUSY -> next cycle busy_o=0, a2f_id_o=0. A new grant after reset starts searching at ch0.
